// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if
//   Bundles the fetch-stage control inputs, the instruction-memory bus and
//   the IF/ID register outputs of instr_fetch_unit into one interface.
//   master : the fetch unit itself. It drives imem_addr and the IF/ID and
//            status outputs, and receives the control inputs and imem_data.
//   slave  : the surroundings (hazard unit, EX redirect, instruction memory).
//   Signals:
//     start, stall, redirect, redirect_pc : pipeline control into fetch
//     imem_addr, imem_data                : combinational instruction memory bus
//     if_id_ir, if_id_pc4, if_id_valid    : IF/ID pipeline register
//     fetch_count, halted, addr_err       : status
interface instr_fetch_unit_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             stall;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_data;
    logic [31:0]      if_id_ir;
    logic [31:0]      if_id_pc4;
    logic             if_id_valid;
    logic [CNT_W-1:0] fetch_count;
    logic             halted;
    logic             addr_err;

    modport master (
        input  start, stall, redirect, redirect_pc, imem_data,
        output imem_addr, if_id_ir, if_id_pc4, if_id_valid,
               fetch_count, halted, addr_err
    );

    modport slave (
        output start, stall, redirect, redirect_pc, imem_data,
        input  imem_addr, if_id_ir, if_id_pc4, if_id_valid,
               fetch_count, halted, addr_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage of the 5-stage MIPS pipeline. Presents the PC to a
//   combinational instruction memory and captures the returned word into
//   the IF/ID register. Handles start-up from IDLE, hazard stalls,
//   branch/jump redirects, halting at the end of memory and trapping on a
//   misaligned redirect target.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : instr_fetch_unit_if.master (control in, imem bus, IF/ID out)
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 128,
    parameter int          CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [31:0]      MEM_BYTES = 32'(MEM_WORDS) << 2;
    localparam logic [31:0]      LAST_PC   = MEM_BYTES - 32'd4;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // The low two bits of RESET_PC are dropped so the PC is word aligned
    // from the very first cycle.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [1:0]       state;
    logic [31:0]      pc;
    logic [31:0]      ir;
    logic [31:0]      pc4;
    logic             valid;
    logic [CNT_W-1:0] count;
    logic             halted;
    logic             addr_err;
    logic [31:0]      pc_plus4;

    assign pc_plus4 = pc + 32'd4;

    // halted is a flop written together with the HALT transition, so it
    // rises on the same edge that enters HALT. Every RUN path that leaves
    // for HALT also sets it. Redirect always flushes IF/ID, even when a
    // stall is present, because the word in flight is on the wrong path.
    // A PC at or beyond the end of memory is never captured: that fetch
    // slot becomes a bubble and the unit halts instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC_ALIGNED;
            ir       <= 32'd0;
            pc4      <= 32'd0;
            valid    <= 1'b0;
            count    <= '0;
            halted   <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.redirect) begin
                        ir    <= 32'd0;
                        valid <= 1'b0;
                        if (bus.redirect_pc[1:0] == 2'b00) begin
                            pc <= bus.redirect_pc;
                        end else begin
                            addr_err <= 1'b1;
                            state    <= ST_HALT;
                            halted   <= 1'b1;
                        end
                    end else if (!bus.stall) begin
                        if (pc >= MEM_BYTES) begin
                            ir     <= 32'd0;
                            valid  <= 1'b0;
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end else begin
                            ir    <= bus.imem_data;
                            pc4   <= pc_plus4;
                            valid <= 1'b1;
                            pc    <= pc_plus4;
                            if (count != CNT_MAX) begin
                                count <= count + 1'b1;
                            end
                            if (pc == LAST_PC) begin
                                state  <= ST_HALT;
                                halted <= 1'b1;
                            end
                        end
                    end
                end
                ST_HALT: begin
                    // Let the last captured word drain into ID once the
                    // stall lifts; after that IF/ID stays a bubble.
                    if (!bus.stall) begin
                        ir    <= 32'd0;
                        valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.if_id_ir    = ir;
    assign bus.if_id_pc4   = pc4;
    assign bus.if_id_valid = valid;
    assign bus.fetch_count = count;
    assign bus.halted      = halted;
    assign bus.addr_err    = addr_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Directed test of instr_fetch_unit. A 128-word instance covers start-up,
//   stall, redirect, misaligned trap, async reset and end-of-memory cases;
//   a 4-word instance covers a short run to the end of memory.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.CNT_W(16)) ifa ();
    instr_fetch_unit_if #(.CNT_W(16)) ifb ();

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .MEM_WORDS(128),
        .CNT_W    (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifa)
    );

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .MEM_WORDS(4),
        .CNT_W    (16)
    ) dut_small (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifb)
    );

    logic [31:0] mem [0:127];

    // Combinational instruction memory; addresses past the array return a
    // marker word that must never be captured.
    function automatic logic [31:0] memRead(input logic [31:0] addr);
        if (addr[31:9] != 23'd0) return 32'hDEAD_BEEF;
        return mem[addr[8:2]];
    endfunction

    always_comb ifa.imem_data = memRead(ifa.imem_addr);
    always_comb ifb.imem_data = memRead(ifb.imem_addr);

    int checks = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic stl, input logic rd, input logic [31:0] rpc);
        ifa.start       = st;
        ifa.stall       = stl;
        ifa.redirect    = rd;
        ifa.redirect_pc = rpc;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_addr"},     ifa.imem_addr,   32'h0);
        checkOutput({tag, "_ir"},       ifa.if_id_ir,    32'h0);
        checkOutput({tag, "_pc4"},      ifa.if_id_pc4,   32'h0);
        checkOutput({tag, "_valid"},    ifa.if_id_valid, 32'h0);
        checkOutput({tag, "_count"},    ifa.fetch_count, 32'h0);
        checkOutput({tag, "_halted"},   ifa.halted,      32'h0);
        checkOutput({tag, "_addr_err"}, ifa.addr_err,    32'h0);
        checkOutput({tag, "_small_count"}, ifb.fetch_count, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 | i;
        mem[0] = 32'h0022_2820;
        mem[1] = 32'h2061_0006;
        mem[2] = 32'h0082_3022;

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        ifb.start       = 1'b0;
        ifb.stall       = 1'b0;
        ifb.redirect    = 1'b0;
        ifb.redirect_pc = 32'h0;

        #2;
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Start-up and in-order fetch of the first three words
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        ifb.start = 1'b1;
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        ifb.start = 1'b0;
        checkOutput("latency_valid", ifa.if_id_valid, 32'h0);
        tick;
        checkOutput("f0_ir",    ifa.if_id_ir,    32'h0022_2820);
        checkOutput("f0_pc4",   ifa.if_id_pc4,   32'h4);
        checkOutput("f0_valid", ifa.if_id_valid, 32'h1);
        checkOutput("f0_count", ifa.fetch_count, 32'h1);
        tick;
        checkOutput("f1_ir",  ifa.if_id_ir,  32'h2061_0006);
        checkOutput("f1_pc4", ifa.if_id_pc4, 32'h8);
        tick;
        checkOutput("f2_ir",    ifa.if_id_ir,    32'h0082_3022);
        checkOutput("f2_pc4",   ifa.if_id_pc4,   32'hC);
        checkOutput("f2_count", ifa.fetch_count, 32'h3);
        checkOutput("f2_addr",  ifa.imem_addr,   32'hC);
        checkOutput("small_f2_count", ifb.fetch_count, 32'h3);

        // Stall on the large instance; the small one runs to its end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick;
            if (k == 0) begin
                checkOutput("small_last_ir",     ifb.if_id_ir,    32'h1000_0003);
                checkOutput("small_last_pc4",    ifb.if_id_pc4,   32'h10);
                checkOutput("small_last_count",  ifb.fetch_count, 32'h4);
                checkOutput("small_last_halted", ifb.halted,      32'h1);
                checkOutput("small_last_valid",  ifb.if_id_valid, 32'h1);
                checkOutput("small_last_addr",   ifb.imem_addr,   32'h10);
            end
            if (k == 1) begin
                checkOutput("small_drain_valid",  ifb.if_id_valid, 32'h0);
                checkOutput("small_drain_halted", ifb.halted,      32'h1);
                checkOutput("small_drain_count",  ifb.fetch_count, 32'h4);
            end
        end
        checkOutput("stall_addr",  ifa.imem_addr,   32'hC);
        checkOutput("stall_ir",    ifa.if_id_ir,    32'h0082_3022);
        checkOutput("stall_count", ifa.fetch_count, 32'h3);
        checkOutput("stall_valid", ifa.if_id_valid, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        checkOutput("resume_ir",    ifa.if_id_ir,    32'h1000_0003);
        checkOutput("resume_pc4",   ifa.if_id_pc4,   32'h10);
        checkOutput("resume_count", ifa.fetch_count, 32'h4);

        // Redirect together with stall: flush wins
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h20);
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("redir_valid", ifa.if_id_valid, 32'h0);
        checkOutput("redir_ir",    ifa.if_id_ir,    32'h0);
        checkOutput("redir_addr",  ifa.imem_addr,   32'h20);
        checkOutput("redir_count", ifa.fetch_count, 32'h4);
        tick;
        checkOutput("target_ir",    ifa.if_id_ir,    32'h1000_0008);
        checkOutput("target_pc4",   ifa.if_id_pc4,   32'h24);
        checkOutput("target_count", ifa.fetch_count, 32'h5);

        // Misaligned redirect target traps and halts
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h22);
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("mis_addr_err", ifa.addr_err,    32'h1);
        checkOutput("mis_halted",   ifa.halted,      32'h1);
        checkOutput("mis_addr",     ifa.imem_addr,   32'h24);
        checkOutput("mis_valid",    ifa.if_id_valid, 32'h0);
        checkOutput("mis_count",    ifa.fetch_count, 32'h5);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("halt_hold_addr",   ifa.imem_addr,   32'h24);
        checkOutput("halt_hold_halted", ifa.halted,      32'h1);
        checkOutput("halt_hold_valid",  ifa.if_id_valid, 32'h0);

        // Async reset asserted between clock edges in the middle of RUN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        tick;
        checkOutput("prerst_count", ifa.fetch_count, 32'h2);
        #3;
        rst_n = 1'b0;
        #1;
        checkResetValues("async_rst");
        tick;
        checkOutput("rst_hold_addr", ifa.imem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        checkOutput("restart_ir",    ifa.if_id_ir,    32'h0022_2820);
        checkOutput("restart_pc4",   ifa.if_id_pc4,   32'h4);
        checkOutput("restart_count", ifa.fetch_count, 32'h1);

        // Redirect to the last legal word, capture it, then drain in HALT
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h1FC);
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("lastw_redir_valid", ifa.if_id_valid, 32'h0);
        checkOutput("lastw_redir_addr",  ifa.imem_addr,   32'h1FC);
        tick;
        checkOutput("lastw_ir",     ifa.if_id_ir,    32'h1000_007F);
        checkOutput("lastw_pc4",    ifa.if_id_pc4,   32'h200);
        checkOutput("lastw_halted", ifa.halted,      32'h1);
        checkOutput("lastw_count",  ifa.fetch_count, 32'h2);
        checkOutput("lastw_valid",  ifa.if_id_valid, 32'h1);
        checkOutput("lastw_addr",   ifa.imem_addr,   32'h200);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick;
        checkOutput("halt_stall_valid", ifa.if_id_valid, 32'h1);
        checkOutput("halt_stall_ir",    ifa.if_id_ir,    32'h1000_007F);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        checkOutput("halt_drain_valid", ifa.if_id_valid, 32'h0);
        checkOutput("halt_drain_ir",    ifa.if_id_ir,    32'h0);
        checkOutput("halt_drain_count", ifa.fetch_count, 32'h2);
        checkOutput("halt_drain_addr",  ifa.imem_addr,   32'h200);

        // Aligned redirect past the end of memory: halt without capture
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h200);
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("oor_redir_valid",  ifa.if_id_valid, 32'h0);
        checkOutput("oor_redir_halted", ifa.halted,      32'h0);
        checkOutput("oor_redir_addr",   ifa.imem_addr,   32'h200);
        tick;
        checkOutput("oor_valid",    ifa.if_id_valid, 32'h0);
        checkOutput("oor_ir",       ifa.if_id_ir,    32'h0);
        checkOutput("oor_halted",   ifa.halted,      32'h1);
        checkOutput("oor_count",    ifa.fetch_count, 32'h1);
        checkOutput("oor_addr_err", ifa.addr_err,    32'h0);
        checkOutput("oor_addr",     ifa.imem_addr,   32'h200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
